master_mode_sequencer: RTL and testbench
========================================

// Module: master_mode_sequencer
// PURPOSE
//   Parametrised master state machine that arbitrates NUM_SLAVES linked sub-state-machines (maze, LED, VGA, ...).
//   Registers a request button per slave and hands control to the selected slave (RUN).
//   Watches that slave's 4-bit status for DONE_CODE, then moves to WIN.
//   Adds abort, run timeout (FAIL), timed return to IDLE, and a sticky completion scoreboard.
// PARAMETERS
//   NUM_SLAVES      3    number of slave machines / request buttons (1..8)
//   SEL_W           2    width of ACTIVE_SEL; must satisfy 2**SEL_W >= NUM_SLAVES
//   DONE_CODE       4'hF slave status value meaning "complete"
//   TIMEOUT_CYCLES  0    RUN cycles before FAIL; 0 disables the timeout
//   WIN_HOLD_CYCLES 0    cycles spent in WIN/FAIL before IDLE; 0 = stay until ABORT or RESET
//   CNT_W           32   width of the internal cycle counter
// PORTS
//   CLK            in   1             system clock
//   RESET          in   1             reset, synchronous, active-high
//   BTN_REQ        in   NUM_SLAVES    raw async request buttons; bit i selects slave i
//   ABORT          in   1             synchronous abort (already clean), level-sensitive
//   SLAVE_STATUS   in   4*NUM_SLAVES  slave i status on bits [4i+3:4i]
//   MASTER_MODE    out  2             00 IDLE, 01 RUN, 10 WIN, 11 FAIL
//   ACTIVE_SEL     out  SEL_W         index of the most recently selected slave
//   ACTIVE_ONEHOT  out  NUM_SLAVES    one-hot enable of ACTIVE_SEL while in RUN, else 0
//   WIN_PULSE      out  1             1-cycle pulse on the RUN->WIN transition
//   FAIL_PULSE     out  1             1-cycle pulse on the RUN->FAIL transition
//   COMPLETED_MASK out  NUM_SLAVES    sticky: bit i set once slave i has reached WIN
//   ALL_DONE       out  1             COMPLETED_MASK is all ones
// BEHAVIOUR
//   Reset: MASTER_MODE=00, ACTIVE_SEL=0, ACTIVE_ONEHOT=0, pulses=0, COMPLETED_MASK=0, counter=0, sync flops=0.
//   Button path, per bit:
//     - Two-flop synchroniser, then prev flop; edge = sync2 & ~prev.
//     - BTN rising before clock edge k gives edge high after edge k+2; the state updates at edge k+3.
//     - Held buttons produce exactly one edge.
//   Counter: cleared on every MASTER_MODE change; otherwise increments, saturating at all ones.
//   IDLE:
//     - Any edge -> RUN; the lowest asserted index wins and is latched into ACTIVE_SEL.
//     - ABORT is ignored in IDLE.
//   RUN (priority order, evaluated each cycle on the selected status only):
//     1. status == DONE_CODE -> WIN; WIN_PULSE=1 for one cycle; set COMPLETED_MASK[ACTIVE_SEL].
//     2. else ABORT -> IDLE.
//     3. else TIMEOUT_CYCLES!=0 and counter == TIMEOUT_CYCLES-1 -> FAIL; FAIL_PULSE=1 for one cycle.
//     - Button edges are ignored in RUN, WIN and FAIL; they are not queued.
//   WIN / FAIL:
//     - ABORT -> IDLE.
//     - Else WIN_HOLD_CYCLES!=0 and counter == WIN_HOLD_CYCLES-1 -> IDLE.
//     - Else hold the state.
//     - ACTIVE_SEL is held so displays can show the finishing slave.
//   Status of non-selected slaves never affects state. Unused MASTER_MODE encodings are unreachable.
//   Outputs are registered except ACTIVE_ONEHOT and ALL_DONE, which are decoded from registers
//   (no input-to-output combinational path).
//   RESET mid-RUN/WIN: return to IDLE next edge, scoreboard cleared, in-flight button edges discarded.
// TESTING
//   1. Reset, BTN_REQ=3'b010 held 5 cycles
//      -> MODE=01 three edges after assertion, ACTIVE_SEL=1, ONEHOT=010, exactly one selection.
//   2. In RUN(sel=1): status1=F, status0=F, status2=0
//      -> WIN next edge, WIN_PULSE one cycle, MASK=010.
//      Separately, in RUN(sel=0): status1=F alone -> no transition.
//   3. BTN_REQ=3'b110 same cycle -> ACTIVE_SEL=1. ABORT during RUN -> IDLE next edge, MASK unchanged.
//   4. TIMEOUT_CYCLES=10, no done -> FAIL exactly 10 cycles after RUN entry, FAIL_PULSE one cycle.
//      Then with done and ABORT both high in RUN -> WIN (done has priority).
//   5. WIN_HOLD_CYCLES=4 -> WIN for 4 cycles, then IDLE.
//      Complete slaves 0,1,2 in turn -> ALL_DONE=1. Assert RESET -> MASK=0, MODE=00.

Source files
------------

// File: rtl/master_mode_sequencer.sv
// Master mode sequencer: picks one of NUM_SLAVES sub-machines from its request button,
// runs it until it reports DONE_CODE, and tracks which slaves have ever completed.
module master_mode_sequencer #(
  parameter int         NUM_SLAVES      = 3,
  parameter int         SEL_W           = 2,
  parameter logic [3:0] DONE_CODE       = 4'hF,
  parameter int         TIMEOUT_CYCLES  = 0,
  parameter int         WIN_HOLD_CYCLES = 0,
  parameter int         CNT_W           = 32
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [NUM_SLAVES-1:0]   BTN_REQ,
  input  logic                    ABORT,
  input  logic [4*NUM_SLAVES-1:0] SLAVE_STATUS,
  output logic [1:0]              MASTER_MODE,
  output logic [SEL_W-1:0]        ACTIVE_SEL,
  output logic [NUM_SLAVES-1:0]   ACTIVE_ONEHOT,
  output logic                    WIN_PULSE,
  output logic                    FAIL_PULSE,
  output logic [NUM_SLAVES-1:0]   COMPLETED_MASK,
  output logic                    ALL_DONE
);

  typedef enum logic [1:0] {
    MODE_IDLE = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_WIN  = 2'b10,
    MODE_FAIL = 2'b11
  } mode_t;

  localparam bit               TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  localparam bit               HOLD_EN      = (WIN_HOLD_CYCLES != 0);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(WIN_HOLD_CYCLES - 1);

  logic [NUM_SLAVES-1:0] sync1_reg;
  logic [NUM_SLAVES-1:0] sync2_reg;
  logic [NUM_SLAVES-1:0] prev_reg;
  logic [NUM_SLAVES-1:0] edge_reg;

  mode_t                 mode_reg;
  logic [SEL_W-1:0]      sel_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  win_pulse_reg;
  logic                  fail_pulse_reg;
  logic [NUM_SLAVES-1:0] mask_reg;

  logic [SEL_W-1:0]      pick_sel;
  logic [3:0]            sel_status;
  logic [NUM_SLAVES-1:0] sel_dec;

  // Edge is registered so the FSM only ever sees flopped button information.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      prev_reg  <= '0;
      edge_reg  <= '0;
    end else begin
      sync1_reg <= BTN_REQ;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      edge_reg  <= sync2_reg & ~prev_reg;
    end
  end

  always_comb begin
    pick_sel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (edge_reg[i]) pick_sel = SEL_W'(i);
    end
  end

  always_comb begin
    sel_status = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_reg == SEL_W'(i)) sel_status = SLAVE_STATUS[4*i +: 4];
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_dec
      assign sel_dec[gi] = (sel_reg == SEL_W'(gi));
    end
  endgenerate

  // Every mode change clears the counter; otherwise it counts up and saturates.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      mode_reg       <= MODE_IDLE;
      sel_reg        <= '0;
      cnt_reg        <= '0;
      win_pulse_reg  <= 1'b0;
      fail_pulse_reg <= 1'b0;
      mask_reg       <= '0;
    end else begin
      win_pulse_reg  <= 1'b0;
      fail_pulse_reg <= 1'b0;
      if (cnt_reg != '1) cnt_reg <= cnt_reg + CNT_W'(1);
      case (mode_reg)
        MODE_IDLE: begin
          if (|edge_reg) begin
            mode_reg <= MODE_RUN;
            sel_reg  <= pick_sel;
            cnt_reg  <= '0;
          end
        end
        MODE_RUN: begin
          if (sel_status == DONE_CODE) begin
            mode_reg      <= MODE_WIN;
            win_pulse_reg <= 1'b1;
            mask_reg      <= mask_reg | sel_dec;
            cnt_reg       <= '0;
          end else if (ABORT) begin
            mode_reg <= MODE_IDLE;
            cnt_reg  <= '0;
          end else if (TIMEOUT_EN && cnt_reg == TIMEOUT_LAST) begin
            mode_reg       <= MODE_FAIL;
            fail_pulse_reg <= 1'b1;
            cnt_reg        <= '0;
          end
        end
        MODE_WIN, MODE_FAIL: begin
          if (ABORT || (HOLD_EN && cnt_reg == HOLD_LAST)) begin
            mode_reg <= MODE_IDLE;
            cnt_reg  <= '0;
          end
        end
        default: begin
          mode_reg <= MODE_IDLE;
          cnt_reg  <= '0;
        end
      endcase
    end
  end

  assign MASTER_MODE    = mode_reg;
  assign ACTIVE_SEL     = sel_reg;
  assign ACTIVE_ONEHOT  = (mode_reg == MODE_RUN) ? sel_dec : '0;
  assign WIN_PULSE      = win_pulse_reg;
  assign FAIL_PULSE     = fail_pulse_reg;
  assign COMPLETED_MASK = mask_reg;
  assign ALL_DONE       = &mask_reg;

endmodule

// File: tb/tb_master_mode_sequencer.sv
// Bench for master_mode_sequencer: dut0 has no timeout/hold, dut1 has TIMEOUT=10, HOLD=4.
module tb_master_mode_sequencer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        ABORT = 1'b0;
  logic [2:0]  BTN = 3'b000;
  logic [11:0] STATUS = 12'h000;

  logic [1:0] mode_o[2];
  logic [1:0] sel_o[2];
  logic [2:0] onehot_o[2];
  logic [2:0] mask_o[2];
  logic       win_o[2];
  logic       fail_o[2];
  logic       alld_o[2];

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      master_mode_sequencer #(
        .NUM_SLAVES(3), .SEL_W(2), .DONE_CODE(4'hF),
        .TIMEOUT_CYCLES(gi == 0 ? 0 : 10), .WIN_HOLD_CYCLES(gi == 0 ? 0 : 4), .CNT_W(32)
      ) dut (
        .CLK(CLK), .RESET(RESET), .BTN_REQ(BTN), .ABORT(ABORT), .SLAVE_STATUS(STATUS),
        .MASTER_MODE(mode_o[gi]), .ACTIVE_SEL(sel_o[gi]), .ACTIVE_ONEHOT(onehot_o[gi]),
        .WIN_PULSE(win_o[gi]), .FAIL_PULSE(fail_o[gi]), .COMPLETED_MASK(mask_o[gi]),
        .ALL_DONE(alld_o[gi])
      );
    end
  endgenerate

  // Reference model: modes 0 IDLE, 1 RUN, 2 WIN, 3 FAIL; "elapsed" = cycles spent in the current mode.
  int         m_mode[2];
  int         m_sel[2];
  int         m_elapsed[2];
  logic [2:0] m_mask[2];
  logic       m_win[2];
  logic       m_fail[2];
  logic [2:0] hist[4];
  int         limit_run[2]  = '{0, 10};
  int         limit_hold[2] = '{0, 4};

  task automatic step();
    logic [2:0] fresh;
    logic [3:0] st;
    int nm;
    @(posedge CLK);
    // A press sampled three edges ago that was absent four edges ago is acted on now.
    fresh = hist[2] & ~hist[3];
    for (int d = 0; d < 2; d++) begin
      if (RESET) begin
        m_mode[d] = 0; m_sel[d] = 0; m_elapsed[d] = 0;
        m_mask[d] = 3'b000; m_win[d] = 1'b0; m_fail[d] = 1'b0;
      end else begin
        nm = m_mode[d];
        m_win[d] = 1'b0;
        m_fail[d] = 1'b0;
        st = STATUS[4*m_sel[d] +: 4];
        if (m_mode[d] == 0) begin
          if (fresh != 3'b000) begin
            nm = 1;
            m_sel[d] = fresh[0] ? 0 : (fresh[1] ? 1 : 2);
          end
        end else if (m_mode[d] == 1) begin
          if (st == 4'hF) begin
            nm = 2; m_win[d] = 1'b1; m_mask[d][m_sel[d]] = 1'b1;
          end else if (ABORT) begin
            nm = 0;
          end else if (limit_run[d] != 0 && m_elapsed[d] + 1 == limit_run[d]) begin
            nm = 3; m_fail[d] = 1'b1;
          end
        end else begin
          if (ABORT || (limit_hold[d] != 0 && m_elapsed[d] + 1 == limit_hold[d])) nm = 0;
        end
        m_elapsed[d] = (nm != m_mode[d]) ? 0 : m_elapsed[d] + 1;
        m_mode[d] = nm;
      end
    end
    if (RESET) begin
      hist = '{default: 3'b000};
    end else begin
      hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = BTN;
    end
    @(negedge CLK);
  endtask

  task automatic press(input logic [2:0] b);
    BTN = b;
    repeat (4) step();
    BTN = 3'b000;
  endtask

  task automatic go_idle();
    ABORT = 1'b1;
    step();
    ABORT = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    BTN = 3'b111;
    repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({mode_o[d], sel_o[d], onehot_o[d], win_o[d], fail_o[d], mask_o[d], alld_o[d]} !== 13'd0) begin
        errors++;
        $display("FAIL reset_state dut%0d got=%0h want=0", d,
                 {mode_o[d], sel_o[d], onehot_o[d], win_o[d], fail_o[d], mask_o[d], alld_o[d]});
      end
    end
    RESET = 1'b0;
    BTN = 3'b000;
    repeat (5) step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (mode_o[d] !== 2'd0) begin
        errors++;
        $display("FAIL reset_no_spurious dut%0d got=%0d want=0", d, mode_o[d]);
      end
    end
    $display("test_reset: outputs cleared, no selection after release");
  endtask

  task automatic test_select();
    BTN = 3'b010;
    for (int j = 1; j <= 9; j++) begin
      if (j == 5) ABORT = 1'b1;
      if (j == 6) begin ABORT = 1'b0; BTN = 3'b000; end
      step();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (mode_o[d] !== ((j == 4) ? 2'd1 : 2'd0)) begin
          errors++;
          $display("FAIL select_mode dut%0d cycle=%0d got=%0d want=%0d", d, j, mode_o[d], (j == 4) ? 1 : 0);
        end
        if (j == 4) begin
          checks++;
          if (sel_o[d] !== 2'd1 || onehot_o[d] !== 3'b010) begin
            errors++;
            $display("FAIL select_sel dut%0d got sel=%0d onehot=%b want sel=1 onehot=010", d, sel_o[d], onehot_o[d]);
          end
        end
      end
    end
    $display("test_select: btn=010 held, single selection of slave 1");
  endtask

  task automatic test_done();
    press(3'b010);
    STATUS = 12'h0FF;
    step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (mode_o[d] !== 2'd2 || win_o[d] !== 1'b1 || mask_o[d] !== 3'b010) begin
        errors++;
        $display("FAIL done_win dut%0d got mode=%0d pulse=%b mask=%b want mode=2 pulse=1 mask=010",
                 d, mode_o[d], win_o[d], mask_o[d]);
      end
    end
    STATUS = 12'h000;
    step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (win_o[d] !== 1'b0 || mode_o[d] !== 2'd2) begin
        errors++;
        $display("FAIL done_pulse_width dut%0d got mode=%0d pulse=%b want mode=2 pulse=0", d, mode_o[d], win_o[d]);
      end
    end
    go_idle();
    STATUS = 12'h0F0;
    press(3'b001);
    for (int j = 0; j < 5; j++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (mode_o[d] !== 2'd1 || sel_o[d] !== 2'd0 || win_o[d] !== 1'b0 || mask_o[d] !== 3'b010) begin
          errors++;
          $display("FAIL done_other_slave dut%0d got mode=%0d sel=%0d mask=%b want mode=1 sel=0 mask=010",
                   d, mode_o[d], sel_o[d], mask_o[d]);
        end
      end
    end
    STATUS = 12'h000;
    go_idle();
    $display("test_done: selected slave wins, non-selected done ignored");
  endtask

  task automatic test_priority_abort();
    press(3'b110);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (mode_o[d] !== 2'd1 || sel_o[d] !== 2'd1 || onehot_o[d] !== 3'b010) begin
        errors++;
        $display("FAIL prio_sel dut%0d got mode=%0d sel=%0d want mode=1 sel=1", d, mode_o[d], sel_o[d]);
      end
    end
    go_idle();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (mode_o[d] !== 2'd0 || mask_o[d] !== 3'b010 || onehot_o[d] !== 3'b000) begin
        errors++;
        $display("FAIL abort_run dut%0d got mode=%0d mask=%b want mode=0 mask=010", d, mode_o[d], mask_o[d]);
      end
    end
    $display("test_priority_abort: btn=110 selects 1, abort returns to idle");
  endtask

  task automatic test_timeout();
    press(3'b001);
    for (int j = 1; j <= 11; j++) begin
      step();
      checks++;
      if (mode_o[1] !== ((j < 10) ? 2'd1 : 2'd3) || fail_o[1] !== (j == 10)) begin
        errors++;
        $display("FAIL timeout dut1 cycle=%0d got mode=%0d pulse=%b want mode=%0d pulse=%0d",
                 j, mode_o[1], fail_o[1], (j < 10) ? 1 : 3, (j == 10) ? 1 : 0);
      end
      checks++;
      if (mode_o[0] !== 2'd1 || fail_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL no_timeout dut0 cycle=%0d got mode=%0d want=1", j, mode_o[0]);
      end
    end
    go_idle();
    press(3'b100);
    STATUS = 12'hF00;
    ABORT = 1'b1;
    step();
    ABORT = 1'b0;
    STATUS = 12'h000;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (mode_o[d] !== 2'd2 || win_o[d] !== 1'b1 || mask_o[d] !== 3'b110) begin
        errors++;
        $display("FAIL done_over_abort dut%0d got mode=%0d pulse=%b mask=%b want mode=2 pulse=1 mask=110",
                 d, mode_o[d], win_o[d], mask_o[d]);
      end
    end
    for (int j = 1; j <= 4; j++) begin
      step();
      checks++;
      if (mode_o[1] !== ((j < 4) ? 2'd2 : 2'd0) || mode_o[0] !== 2'd2) begin
        errors++;
        $display("FAIL win_hold cycle=%0d got dut0=%0d dut1=%0d want dut0=2 dut1=%0d",
                 j, mode_o[0], mode_o[1], (j < 4) ? 2 : 0);
      end
    end
    go_idle();
    $display("test_timeout: fail after 10 run cycles, done beats abort, win held 4");
  endtask

  task automatic test_all_done();
    logic [2:0] want;
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    want = 3'b000;
    for (int s = 0; s < 3; s++) begin
      press(3'b001 << s);
      STATUS = 12'h00F << (4 * s);
      step();
      STATUS = 12'h000;
      want[s] = 1'b1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (mask_o[d] !== want || alld_o[d] !== (s == 2) || win_o[d] !== 1'b1) begin
          errors++;
          $display("FAIL all_done dut%0d slave=%0d got mask=%b all=%b want mask=%b all=%0d",
                   d, s, mask_o[d], alld_o[d], want, (s == 2) ? 1 : 0);
        end
      end
      go_idle();
    end
    press(3'b010);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (mask_o[d] !== 3'b000 || mode_o[d] !== 2'd0 || alld_o[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_clears dut%0d got mode=%0d mask=%b want mode=0 mask=000", d, mode_o[d], mask_o[d]);
      end
    end
    $display("test_all_done: all slaves completed, reset clears scoreboard");
  endtask

  task automatic test_random();
    logic [12:0] obs;
    logic [12:0] exp;
    logic [2:0]  oh;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) BTN = 3'($urandom_range(0, 7));
      ABORT = ($urandom_range(0, 9) == 0);
      RESET = ($urandom_range(0, 99) == 0);
      for (int s = 0; s < 3; s++)
        STATUS[4*s +: 4] = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      step();
      for (int d = 0; d < 2; d++) begin
        oh  = (m_mode[d] == 1) ? 3'(1 << m_sel[d]) : 3'b000;
        exp = {2'(m_mode[d]), 2'(m_sel[d]), oh, m_win[d], m_fail[d], m_mask[d], &m_mask[d]};
        obs = {mode_o[d], sel_o[d], onehot_o[d], win_o[d], fail_o[d], mask_o[d], alld_o[d]};
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL random dut%0d cycle=%0d got=%h want=%h", d, n, obs, exp);
        end
      end
      $display("random %0d: btn=%b abort=%b rst=%b status=%h mode=%0d/%0d", n, BTN, ABORT, RESET, STATUS,
               mode_o[0], mode_o[1]);
    end
    RESET = 1'b0;
    ABORT = 1'b0;
    BTN = 3'b000;
  endtask

  initial begin
    test_reset();
    test_select();
    test_done();
    test_priority_abort();
    test_timeout();
    test_all_done();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
